tee_axil_arbiter: RTL and testbench
===================================

Name: tee_axil_arbiter

Overview:
Two-master to one-slave AXI4-Lite arbiter for the TEE comm agent. It shares a single register-file slave between S00 (host side) and S01 (TEE side). It runs one transaction at a time, whole and unsplit, with 4-way round-robin among S00-write, S00-read, S01-write and S01-read. It sits between the two AXI master ports and the agent's register bank.

Parameters:
ADDR_WIDTH, 4, AXI4-Lite address width (byte address).
DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported.

Ports:
ACLK  in  1  system clock; all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
Port groups:
- Three AXI4-Lite groups: prefix s00_axi_, s01_axi_ and m_axi_.
- Directions below are for the s00_/s01_ groups; m_axi_ uses the inverse direction.
s*_axi_awaddr  in  ADDR_WIDTH  write address
s*_axi_awprot  in  3  write protection
s*_axi_awvalid / s*_axi_awready  in / out  1 / 1  AW handshake
s*_axi_wdata  in  DATA_WIDTH  write data
s*_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s*_axi_wvalid / s*_axi_wready  in / out  1 / 1  W handshake
s*_axi_bresp  out  2  write response
s*_axi_bvalid / s*_axi_bready  out / in  1 / 1  B handshake
s*_axi_araddr  in  ADDR_WIDTH  read address
s*_axi_arprot  in  3  read protection
s*_axi_arvalid / s*_axi_arready  in / out  1 / 1  AR handshake
s*_axi_rdata  out  DATA_WIDTH  read data
s*_axi_rresp  out  2  read response
s*_axi_rvalid / s*_axi_rready  out / in  1 / 1  R handshake
grant  out  4  one-hot current owner: bit0 S00-wr, bit1 S00-rd, bit2 S01-wr, bit3 S01-rd
busy  out  1  high when state is not IDLE

Behaviour:
Reset:
- All valid and ready outputs are 0; grant=0, busy=0; bresp/rresp/rdata=0.
- Round-robin pointer points to S00-wr.
- Reset asserted mid-transaction aborts it immediately; the masters are reset by the same ARESETN.
Request terms:
- Write request: awvalid && wvalid.
- Read request: arvalid.
- Four request bits are evaluated only in IDLE.
States:
- IDLE: if any request is active, grant the first one at or after the pointer (cyclic order 0,1,2,3). The grant register is loaded and the next state is WADDR (write) or RADDR (read). Stay in IDLE if there is no request. Arbitration costs exactly 1 cycle.
- WADDR:
  - m_axi_aw*/w* are driven combinationally from the granted port, muxed by the registered grant.
  - Granted s_awready = m_awready && !aw_done; granted s_wready = m_wready && !w_done.
  - aw_done and w_done flags record completed handshakes; m_awvalid/m_wvalid drop once their own flag is set.
  - When both are done, go to WRESP.
- WRESP: granted s_bvalid=m_bvalid, s_bresp=m_bresp, m_bready=granted s_bready. On the B handshake: clear grant, set pointer = granted index + 1 (mod 4), go to IDLE.
- RADDR: forward AR with the same mux rule. On the AR handshake, go to RDATA.
- RDATA: forward R (rdata, rresp, rvalid, rready). On the R handshake: release and update the pointer as in WRESP, go to IDLE.
Other rules:
- Non-granted ports see all ready and valid outputs at 0.
- Simultaneous requests are resolved by the pointer only.
- Write and read from the same port are independent requesters.
- Exactly one transaction is outstanding on m_axi_ at any time.
- Minimum occupancy: 1 arbitration cycle + 1 address/data cycle + 1 response cycle.
- Back-to-back transactions have at least 1 IDLE cycle between them.

Optional Feature:
TEE_ARB_LOCK_EN
Enabled:
- Adds an input s01_lock (1 bit) and an output s00_denied_cnt (16 bits, reset 0).
- While s01_lock=1 at grant time, S00 requests are still arbitrated but are not forwarded to m_axi_.
- The arbiter completes them locally: it accepts AW/W (or AR) in the cycle after grant.
- It then returns bresp=2'b10 (SLVERR), or rresp=2'b10 with rdata=0, on the following cycle and holds until the master is ready.
- s00_denied_cnt increments by 1 per denied transaction and saturates at 16'hFFFF.
- A change of s01_lock during an active transaction does not affect that transaction.
Disabled: the port and counter do not exist; all transactions are forwarded.

Test Plan:
- S00 writes 0x00000001 to addr 0x0, then reads addr 0x0 -> m_axi_ sees one write then one read; S00 reads back 0x00000001 with rresp=0; grant shows 0001, then 0010.
- S00 and S01 assert writes in the same cycle (addresses 0x4 and 0x8) -> S00 is served first, then S01 (pointer order); m_axi_ never has overlapping transactions.
- All four requesters held continuously for 8 transactions -> grant sequence 1,2,4,8,1,2,4,8; no requester is starved.
- Slave holds awready=0 for 5 cycles while wready=1 -> W completes first and AW later; exactly one B is returned to the owner; busy stays high throughout.
- ARESETN pulsed low during RDATA -> all outputs return to 0 asynchronously; the next request after reset is served from pointer 0.
- TEE_ARB_LOCK_EN with s01_lock=1: S00 writes 0x5 to 0x0 -> bresp=2'b10, m_axi_awvalid is never asserted, s00_denied_cnt=1; after s01_lock=0, the S00 read of 0x0 returns the prior value.

Source files
------------

// File: rtl/tee_axil_arbiter.sv
// tee_axil_arbiter
//   Two-master to one-slave AXI4-Lite arbiter for the TEE comm agent.
//   S00 (host) and S01 (TEE) share one register-file slave on m_axi_.
//   One whole transaction at a time. Round-robin runs over four requesters:
//   0 = S00 write, 1 = S00 read, 2 = S01 write, 3 = S01 read.
//
// Ports
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   s00_axi_*, s01_axi_*  AXI4-Lite slave ports (from the two masters)
//   m_axi_*               AXI4-Lite master port (to the register bank)
//   grant[3:0]            registered one-hot owner (bit order as above)
//   busy                  registered, high whenever the FSM is not IDLE
//
// Optional feature (macro TEE_ARB_LOCK_EN)
//   s01_lock        while high at grant time, S00 transactions are completed
//                   locally with SLVERR and are never forwarded to m_axi_.
//   s00_denied_cnt  saturating count of such denied transactions.
module tee_axil_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    // S00 (host)
    input  logic [ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                s00_axi_awprot,
    input  logic                      s00_axi_awvalid,
    output logic                      s00_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                      s00_axi_wvalid,
    output logic                      s00_axi_wready,
    output logic [1:0]                s00_axi_bresp,
    output logic                      s00_axi_bvalid,
    input  logic                      s00_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                s00_axi_arprot,
    input  logic                      s00_axi_arvalid,
    output logic                      s00_axi_arready,
    output logic [DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                s00_axi_rresp,
    output logic                      s00_axi_rvalid,
    input  logic                      s00_axi_rready,
    // S01 (TEE)
    input  logic [ADDR_WIDTH-1:0]     s01_axi_awaddr,
    input  logic [2:0]                s01_axi_awprot,
    input  logic                      s01_axi_awvalid,
    output logic                      s01_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s01_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s01_axi_wstrb,
    input  logic                      s01_axi_wvalid,
    output logic                      s01_axi_wready,
    output logic [1:0]                s01_axi_bresp,
    output logic                      s01_axi_bvalid,
    input  logic                      s01_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s01_axi_araddr,
    input  logic [2:0]                s01_axi_arprot,
    input  logic                      s01_axi_arvalid,
    output logic                      s01_axi_arready,
    output logic [DATA_WIDTH-1:0]     s01_axi_rdata,
    output logic [1:0]                s01_axi_rresp,
    output logic                      s01_axi_rvalid,
    input  logic                      s01_axi_rready,
    // Shared slave
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
`ifdef TEE_ARB_LOCK_EN
    input  logic                      s01_lock,
    output logic [15:0]               s00_denied_cnt,
`endif
    output logic [3:0]                grant,
    output logic                      busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA
    } state_t;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] ptr_q, ptr_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       busy_q, busy_d;
    logic       deny;

`ifdef TEE_ARB_LOCK_EN
    logic        deny_q, deny_d;
    logic [15:0] cnt_q, cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign deny           = deny_q;
    assign s00_denied_cnt = cnt_q;
`else
    assign deny = 1'b0;
`endif

    // Requests, evaluated only in IDLE.
    logic [3:0] req;
    assign req = {s01_axi_arvalid, s01_axi_awvalid & s01_axi_wvalid,
                  s00_axi_arvalid, s00_axi_awvalid & s00_axi_wvalid};

    // First active request at or after the pointer, in cyclic order.
    logic       pick_found;
    logic [1:0] pick_idx, cand;
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Muxing of the granted master, keyed by the registered grant.
    logic own00, own01;
    logic [1:0] own_idx;
    assign own00   = grant_q[0] | grant_q[1];
    assign own01   = grant_q[2] | grant_q[3];
    assign own_idx = {own01, grant_q[1] | grant_q[3]};

    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    assign g_awvalid = own01 ? s01_axi_awvalid : s00_axi_awvalid;
    assign g_wvalid  = own01 ? s01_axi_wvalid  : s00_axi_wvalid;
    assign g_bready  = own01 ? s01_axi_bready  : s00_axi_bready;
    assign g_arvalid = own01 ? s01_axi_arvalid : s00_axi_arvalid;
    assign g_rready  = own01 ? s01_axi_rready  : s00_axi_rready;

    assign m_axi_awaddr  = own01 ? s01_axi_awaddr : s00_axi_awaddr;
    assign m_axi_awprot  = own01 ? s01_axi_awprot : s00_axi_awprot;
    assign m_axi_wdata   = own01 ? s01_axi_wdata  : s00_axi_wdata;
    assign m_axi_wstrb   = own01 ? s01_axi_wstrb  : s00_axi_wstrb;
    assign m_axi_araddr  = own01 ? s01_axi_araddr : s00_axi_araddr;
    assign m_axi_arprot  = own01 ? s01_axi_arprot : s00_axi_arprot;

    // A denied transaction never reaches m_axi_; the arbiter answers itself.
    assign m_axi_awvalid = (state_q == ST_WADDR) && !deny && g_awvalid && !aw_done_q;
    assign m_axi_wvalid  = (state_q == ST_WADDR) && !deny && g_wvalid  && !w_done_q;
    assign m_axi_bready  = (state_q == ST_WRESP) && !deny && g_bready;
    assign m_axi_arvalid = (state_q == ST_RADDR) && !deny && g_arvalid;
    assign m_axi_rready  = (state_q == ST_RDATA) && !deny && g_rready;

    // Responses toward the granted master.
    logic                  awready_g, wready_g, bvalid_g, arready_g, rvalid_g;
    logic [1:0]            bresp_g, rresp_g;
    logic [DATA_WIDTH-1:0] rdata_g;
    assign awready_g = (state_q == ST_WADDR) && !aw_done_q && (deny || m_axi_awready);
    assign wready_g  = (state_q == ST_WADDR) && !w_done_q  && (deny || m_axi_wready);
    assign bvalid_g  = (state_q == ST_WRESP) && (deny || m_axi_bvalid);
    assign bresp_g   = (state_q != ST_WRESP) ? 2'b00 : (deny ? RESP_SLVERR : m_axi_bresp);
    assign arready_g = (state_q == ST_RADDR) && (deny || m_axi_arready);
    assign rvalid_g  = (state_q == ST_RDATA) && (deny || m_axi_rvalid);
    assign rresp_g   = (state_q != ST_RDATA) ? 2'b00 : (deny ? RESP_SLVERR : m_axi_rresp);
    assign rdata_g   = ((state_q == ST_RDATA) && !deny) ? m_axi_rdata : '0;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = awready_g && g_awvalid;
    assign w_hs  = wready_g  && g_wvalid;
    assign b_hs  = bvalid_g  && g_bready;
    assign ar_hs = arready_g && g_arvalid;
    assign r_hs  = rvalid_g  && g_rready;

    assign s00_axi_awready = own00 & awready_g;
    assign s00_axi_wready  = own00 & wready_g;
    assign s00_axi_bvalid  = own00 & bvalid_g;
    assign s00_axi_bresp   = own00 ? bresp_g : 2'b00;
    assign s00_axi_arready = own00 & arready_g;
    assign s00_axi_rvalid  = own00 & rvalid_g;
    assign s00_axi_rresp   = own00 ? rresp_g : 2'b00;
    assign s00_axi_rdata   = own00 ? rdata_g : '0;

    assign s01_axi_awready = own01 & awready_g;
    assign s01_axi_wready  = own01 & wready_g;
    assign s01_axi_bvalid  = own01 & bvalid_g;
    assign s01_axi_bresp   = own01 ? bresp_g : 2'b00;
    assign s01_axi_arready = own01 & arready_g;
    assign s01_axi_rvalid  = own01 & rvalid_g;
    assign s01_axi_rresp   = own01 ? rresp_g : 2'b00;
    assign s01_axi_rdata   = own01 ? rdata_g : '0;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef TEE_ARB_LOCK_EN
        deny_d    = deny_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d   = 4'b0001 << pick_idx;
                    state_d   = pick_idx[0] ? ST_RADDR : ST_WADDR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef TEE_ARB_LOCK_EN
                    // Lock is sampled once here and held for the whole transaction.
                    deny_d = s01_lock && !pick_idx[1];
                    if (s01_lock && !pick_idx[1]) cnt_d = sat_inc16(cnt_q);
`endif
                end
            end
            ST_WADDR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                if (b_hs) begin
                    grant_d = 4'b0000;
                    ptr_d   = own_idx + 2'd1;
                    state_d = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (ar_hs) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (r_hs) begin
                    grant_d = 4'b0000;
                    ptr_d   = own_idx + 2'd1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            grant_q   <= 4'b0000;
            ptr_q     <= 2'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef TEE_ARB_LOCK_EN
            deny_q    <= 1'b0;
            cnt_q     <= 16'h0000;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            busy_q    <= busy_d;
`ifdef TEE_ARB_LOCK_EN
            deny_q    <= deny_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_tee_axil_arbiter.sv
// Testbench for tee_axil_arbiter: two AXI4-Lite master drivers, a small
// register-file slave on m_axi_, per-requester expected-response queues and a
// grant-sequence queue popped by an independent monitor.
module tb_tee_axil_arbiter;

    logic ACLK = 1'b0;
    logic ARESETN;
    always #5 ACLK = ~ACLK;

    // Master-side stimulus, index 0 = S00, 1 = S01.
    logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]  awaddr [2];
    logic [3:0]  araddr [2];
    logic [31:0] wdata  [2];
    logic [2:0]  prot;
    logic [3:0]  strb;
    logic [1:0]  awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp [2];
    logic [1:0]  rresp [2];
    logic [31:0] rdata [2];

    logic [3:0]  m_awaddr, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic [3:0]  grant;
    logic        busy;
`ifdef TEE_ARB_LOCK_EN
    logic        s01_lock;
    logic [15:0] denied_cnt;
`endif

    tee_axil_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s00_axi_awaddr(awaddr[0]), .s00_axi_awprot(prot), .s00_axi_awvalid(awvalid[0]),
        .s00_axi_awready(awready[0]), .s00_axi_wdata(wdata[0]), .s00_axi_wstrb(strb),
        .s00_axi_wvalid(wvalid[0]), .s00_axi_wready(wready[0]), .s00_axi_bresp(bresp[0]),
        .s00_axi_bvalid(bvalid[0]), .s00_axi_bready(bready[0]), .s00_axi_araddr(araddr[0]),
        .s00_axi_arprot(prot), .s00_axi_arvalid(arvalid[0]), .s00_axi_arready(arready[0]),
        .s00_axi_rdata(rdata[0]), .s00_axi_rresp(rresp[0]), .s00_axi_rvalid(rvalid[0]),
        .s00_axi_rready(rready[0]),
        .s01_axi_awaddr(awaddr[1]), .s01_axi_awprot(prot), .s01_axi_awvalid(awvalid[1]),
        .s01_axi_awready(awready[1]), .s01_axi_wdata(wdata[1]), .s01_axi_wstrb(strb),
        .s01_axi_wvalid(wvalid[1]), .s01_axi_wready(wready[1]), .s01_axi_bresp(bresp[1]),
        .s01_axi_bvalid(bvalid[1]), .s01_axi_bready(bready[1]), .s01_axi_araddr(araddr[1]),
        .s01_axi_arprot(prot), .s01_axi_arvalid(arvalid[1]), .s01_axi_arready(arready[1]),
        .s01_axi_rdata(rdata[1]), .s01_axi_rresp(rresp[1]), .s01_axi_rvalid(rvalid[1]),
        .s01_axi_rready(rready[1]),
        .m_axi_awaddr(m_awaddr), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid),
        .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_bresp(m_bresp),
        .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_araddr(m_araddr),
        .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid),
        .m_axi_rready(m_rready),
`ifdef TEE_ARB_LOCK_EN
        .s01_lock(s01_lock), .s00_denied_cnt(denied_cnt),
`endif
        .grant(grant), .busy(busy)
    );

    // Register-file slave with an optional AW stall.
    logic [31:0] mem [4];
    logic        aw_got, w_got, sl_bvalid, sl_rvalid;
    logic [3:0]  aw_a;
    logic [31:0] w_d, sl_rdata;
    int          stall_target = 0;
    int          stall_seen, cyc, aw_hs_cyc, w_hs_cyc;

    assign m_awready = !aw_got && (stall_seen >= stall_target);
    assign m_wready  = !w_got;
    assign m_bvalid  = sl_bvalid;
    assign m_bresp   = 2'b00;
    assign m_arready = !sl_rvalid;
    assign m_rvalid  = sl_rvalid;
    assign m_rdata   = sl_rdata;
    assign m_rresp   = 2'b00;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0; sl_bvalid <= 1'b0; sl_rvalid <= 1'b0;
            sl_rdata <= 32'h0; stall_seen <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_awvalid && !m_awready && stall_seen < stall_target) stall_seen <= stall_seen + 1;
            if (m_awvalid && m_awready) begin
                aw_got <= 1'b1; aw_a <= m_awaddr; aw_hs_cyc <= cyc; stall_seen <= 0;
            end
            if (m_wvalid && m_wready) begin
                w_got <= 1'b1; w_d <= m_wdata; w_hs_cyc <= cyc;
            end
            if (aw_got && w_got && !sl_bvalid) begin
                mem[aw_a[3:2]] <= w_d;
                sl_bvalid <= 1'b1;
            end
            if (sl_bvalid && m_bready) begin
                sl_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (m_arvalid && m_arready) begin
                sl_rvalid <= 1'b1; sl_rdata <= mem[m_araddr[3:2]];
            end
            if (sl_rvalid && m_rready) sl_rvalid <= 1'b0;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected responses per requester {resp, data}; expected grant sequence.
    logic [33:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];
    logic [3:0]  exp_grant_q[$];

    task automatic push_exp(input logic [1:0] r, input logic [1:0] resp, input logic [31:0] d);
        case (r)
            2'd0: exp_q0.push_back({resp, d});
            2'd1: exp_q1.push_back({resp, d});
            2'd2: exp_q2.push_back({resp, d});
            default: exp_q3.push_back({resp, d});
        endcase
    endtask

    task automatic sb_check(input logic [1:0] r, input logic [1:0] resp, input logic [31:0] d);
        logic [33:0] e;
        bit have;
        have = 1'b0;
        e = '0;
        case (r)
            2'd0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            2'd1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            2'd2: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
            default: if (exp_q3.size() > 0) begin e = exp_q3.pop_front(); have = 1'b1; end
        endcase
        chk($sformatf("resp_expected_req%0d", r), {31'h0, have}, 32'h1);
        if (have) begin
            chk($sformatf("resp_code_req%0d", r), {30'h0, resp}, {30'h0, e[33:32]});
            chk($sformatf("resp_data_req%0d", r), d, e[31:0]);
        end
    endtask

    // Monitor: all checking of DUT outputs during normal traffic.
    logic [3:0] prev_grant = 4'b0000;
    bit t4_on = 0, t4_owned = 0, t4_bdone = 0, aw_watch = 0, aw_seen = 0;
    int t4_busy_drop = 0, t4_bcount = 0;

    initial forever begin
        @(negedge ACLK);
        if (ARESETN === 1'b1) begin
            if (bvalid[0] && bready[0]) sb_check(2'd0, bresp[0], 32'h0);
            if (rvalid[0] && rready[0]) sb_check(2'd1, rresp[0], rdata[0]);
            if (bvalid[1] && bready[1]) sb_check(2'd2, bresp[1], 32'h0);
            if (rvalid[1] && rready[1]) sb_check(2'd3, rresp[1], rdata[1]);
            if (grant != prev_grant && grant != 4'b0000) begin
                if (exp_grant_q.size() > 0) chk("grant_seq", {28'h0, grant}, {28'h0, exp_grant_q.pop_front()});
                else chk("grant_unexpected", {28'h0, grant}, 32'h0);
            end
            if (!(grant[0] | grant[1]))
                chk("s00_quiet", {27'h0, awready[0], wready[0], bvalid[0], arready[0], rvalid[0]}, 32'h0);
            if (!(grant[2] | grant[3]))
                chk("s01_quiet", {27'h0, awready[1], wready[1], bvalid[1], arready[1], rvalid[1]}, 32'h0);
            if (m_awvalid || m_wvalid || m_arvalid || m_bready || m_rready)
                chk("m_single_owner",
                    {31'h0, busy && $onehot(grant) && !(m_arvalid && (m_awvalid || m_wvalid))
                            && !(sl_rvalid && (aw_got || w_got || sl_bvalid))}, 32'h1);
            if (aw_watch && m_awvalid) aw_seen = 1;
            if (t4_on) begin
                if (grant == 4'b0001) t4_owned = 1;
                if (t4_owned && !t4_bdone && !busy) t4_busy_drop++;
                if (bvalid[0] && bready[0]) begin t4_bcount++; t4_bdone = 1; end
            end
        end
        prev_grant = grant;
    end

    task automatic do_write(input bit pp, input logic [3:0] a, input logic [31:0] d,
                            input logic [1:0] resp);
        bit awd, wd, aws, ws, bd;
        int n;
        push_exp({pp, 1'b0}, resp, 32'h0);
        awaddr[pp] = a; wdata[pp] = d; awvalid[pp] = 1'b1; wvalid[pp] = 1'b1;
        awd = 0; wd = 0; n = 0;
        while (!(awd && wd) && n < 200) begin
            @(negedge ACLK);
            aws = awvalid[pp] && awready[pp];
            ws  = wvalid[pp] && wready[pp];
            @(posedge ACLK); #1;
            if (aws) begin awvalid[pp] = 1'b0; awd = 1; end
            if (ws)  begin wvalid[pp]  = 1'b0; wd  = 1; end
            n++;
        end
        chk($sformatf("wr_accept_s%0d", pp), {31'h0, awd && wd}, 32'h1);
        bd = 0; n = 0;
        while (!bd && n < 200) begin
            @(negedge ACLK);
            if (bvalid[pp] && bready[pp]) bd = 1;
            n++;
        end
        chk($sformatf("wr_bresp_s%0d", pp), {31'h0, bd}, 32'h1);
        @(posedge ACLK); #1;
    endtask

    task automatic do_read(input bit pp, input logic [3:0] a, input logic [31:0] d);
        bit ard, hs, rd;
        int n;
        push_exp({pp, 1'b1}, 2'b00, d);
        araddr[pp] = a; arvalid[pp] = 1'b1;
        ard = 0; n = 0;
        while (!ard && n < 200) begin
            @(negedge ACLK);
            hs = arvalid[pp] && arready[pp];
            @(posedge ACLK); #1;
            if (hs) begin arvalid[pp] = 1'b0; ard = 1; end
            n++;
        end
        chk($sformatf("rd_accept_s%0d", pp), {31'h0, ard}, 32'h1);
        rd = 0; n = 0;
        while (!rd && n < 200) begin
            @(negedge ACLK);
            if (rvalid[pp] && rready[pp]) rd = 1;
            n++;
        end
        chk($sformatf("rd_data_s%0d", pp), {31'h0, rd}, 32'h1);
        @(posedge ACLK); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got;
        int n;
        ARESETN = 1'b0;
        awvalid = '0; wvalid = '0; arvalid = '0; bready = 2'b11; rready = 2'b11;
        prot = 3'b000; strb = 4'hF; cyc = 0; aw_hs_cyc = 0; w_hs_cyc = 0;
        for (int i = 0; i < 2; i++) begin
            awaddr[i] = 4'h0; araddr[i] = 4'h0; wdata[i] = 32'h0;
        end
`ifdef TEE_ARB_LOCK_EN
        s01_lock = 1'b0;
`endif
        repeat (3) @(negedge ACLK);
        chk("rst_grant", {28'h0, grant}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_s_handshakes", {22'h0, awready, wready, bvalid, arready, rvalid}, 32'h0);
        chk("rst_m_handshakes", {27'h0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 32'h0);
        chk("rst_resp", {24'h0, bresp[0], rresp[0], bresp[1], rresp[1]}, 32'h0);
        chk("rst_rdata0", rdata[0], 32'h0);
        chk("rst_rdata1", rdata[1], 32'h0);
`ifdef TEE_ARB_LOCK_EN
        chk("rst_denied_cnt", {16'h0, denied_cnt}, 32'h0);
`endif
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Simultaneous writes from both hosts: pointer 0 gives S00 first.
        exp_grant_q.push_back(4'b0001);
        exp_grant_q.push_back(4'b0100);
        fork
            do_write(1'b0, 4'h4, 32'hAAAA0004, 2'b00);
            do_write(1'b1, 4'h8, 32'hBBBB0008, 2'b00);
        join

        // S00 write then read of 0x0.
        exp_grant_q.push_back(4'b0001);
        do_write(1'b0, 4'h0, 32'h00000001, 2'b00);
        exp_grant_q.push_back(4'b0010);
        do_read(1'b0, 4'h0, 32'h00000001);
        chk("mem0_after_write", mem[0], 32'h00000001);

        // S01 read of 0x8 returns the pointer to 0.
        exp_grant_q.push_back(4'b1000);
        do_read(1'b1, 4'h8, 32'hBBBB0008);

        // All four requesters continuously active: 1,2,4,8,1,2,4,8.
        for (int k = 0; k < 2; k++) begin
            exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b0010);
            exp_grant_q.push_back(4'b0100); exp_grant_q.push_back(4'b1000);
        end
        fork
            begin do_write(1'b0, 4'h0, 32'h11110000, 2'b00); do_write(1'b0, 4'h0, 32'h22220000, 2'b00); end
            begin do_read(1'b0, 4'h4, 32'hAAAA0004); do_read(1'b0, 4'h4, 32'hAAAA0004); end
            begin do_write(1'b1, 4'hC, 32'h3333000C, 2'b00); do_write(1'b1, 4'hC, 32'h4444000C, 2'b00); end
            begin do_read(1'b1, 4'h8, 32'hBBBB0008); do_read(1'b1, 4'h8, 32'hBBBB0008); end
        join
        chk("mem0_rr_final", mem[0], 32'h22220000);
        chk("memC_rr_final", mem[3], 32'h4444000C);

        // AW stalled 5 cycles while W is accepted at once.
        stall_target = 5;
        t4_on = 1;
        exp_grant_q.push_back(4'b0001);
        do_write(1'b0, 4'h4, 32'hC0DE0004, 2'b00);
        repeat (3) @(posedge ACLK);
        #1;
        t4_on = 0;
        stall_target = 0;
        chk("stall_aw_after_w", aw_hs_cyc - w_hs_cyc, 32'd5);
        chk("stall_one_b", t4_bcount, 32'd1);
        chk("stall_busy_held", t4_busy_drop, 32'd0);
        chk("stall_owner_seen", {31'h0, t4_owned}, 32'h1);

        // Reset asserted while S00 read is in RDATA.
        exp_grant_q.push_back(4'b0010);
        rready[0] = 1'b0;
        araddr[0] = 4'h0;
        arvalid[0] = 1'b1;
        got = 0; n = 0;
        while (!got && n < 100) begin
            @(negedge ACLK);
            if (rvalid[0]) got = 1;
            else if (arready[0]) begin @(posedge ACLK); #1; arvalid[0] = 1'b0; end
            n++;
        end
        chk("rdata_phase_reached", {31'h0, got}, 32'h1);
        arvalid[0] = 1'b0;
        #2 ARESETN = 1'b0;
        #1;
        chk("async_rst_grant", {28'h0, grant}, 32'h0);
        chk("async_rst_busy", {31'h0, busy}, 32'h0);
        chk("async_rst_rvalid", {30'h0, rvalid}, 32'h0);
        chk("async_rst_rdata", rdata[0], 32'h0);
        chk("async_rst_m", {27'h0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 32'h0);
        repeat (2) @(negedge ACLK);
        rready[0] = 1'b1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Pointer restarted at 0: S00 write beats S00 read.
        exp_grant_q.push_back(4'b0001);
        exp_grant_q.push_back(4'b0010);
        fork
            do_write(1'b0, 4'h0, 32'h0D0D0D0D, 2'b00);
            do_read(1'b0, 4'h4, 32'hC0DE0004);
        join

`ifdef TEE_ARB_LOCK_EN
        // Locked: S00 write completed locally with SLVERR.
        s01_lock = 1'b1;
        aw_watch = 1;
        aw_seen = 0;
        exp_grant_q.push_back(4'b0001);
        do_write(1'b0, 4'h0, 32'h00000005, 2'b10);
        aw_watch = 0;
        chk("lock_no_m_awvalid", {31'h0, aw_seen}, 32'h0);
        chk("lock_denied_cnt", {16'h0, denied_cnt}, 32'd1);
        s01_lock = 1'b0;
        exp_grant_q.push_back(4'b0010);
        do_read(1'b0, 4'h0, 32'h0D0D0D0D);
`endif

        repeat (3) @(posedge ACLK);
        #1;
        chk("sb_drained", exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size(), 32'd0);
        chk("grant_seq_drained", exp_grant_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
